ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Round-robin arbiter and sequencer that shares one single-port synchronous RAM (`ram`, 1-cycle registered read) between `NREQ` requesters. Each requester issues read or write commands over a valid/ready handshake. The arbiter grants at most one access per cycle and drives the RAM port. It returns read data to the owning requester exactly one cycle after its grant. It sits between the core-side clients (e.g. fetch and load/store units) and the shared data memory.

## Interface
- `WIDTH`, 8: data word width; matches the RAM's `WIDTH`.
- `DEPTH`, 256: RAM depth. `AW = $clog2(DEPTH)` is the address width.
- `NREQ`, 2: number of requesters, ≥ 2.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: bit i is set when requester i presents a command.
- `req_we`  in  NREQ: bit i selects write (1) or read (0) for requester i.
- `req_addr`  in  NREQ*AW: requester i's address in slice [i*AW +: AW].
- `req_wdata`  in  NREQ*WIDTH: requester i's write data in slice [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ: one-hot or zero; grant to requester i this cycle.
- `rsp_valid`  out  NREQ: one-hot or zero; read data for requester i is valid this cycle.
- `rsp_rdata`  out  WIDTH: read data, shared by all requesters and qualified by `rsp_valid`.
- `ram_we`  out  1: RAM write enable.
- `ram_addr`  out  AW: RAM address.
- `ram_data_in`  out  WIDTH: RAM write data.
- `ram_data_out`  in  WIDTH: RAM registered read data.

## Operation
- Transfer for requester i occurs when `req_valid[i] && req_ready[i]`. A requester holds valid, we, addr and wdata stable until it sees ready. It must not deassert valid before the grant.
- State:
  - `ptr` (NREQ-wide index): the highest-priority requester.
  - `rsp_pend`: registered one-hot `rsp_valid`.
- Grant selection (combinational):
  - Grant the first i with `req_valid[i]` set, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - No valid requesters means no grant.
- `req_ready` is the grant vector. It is forced to 0 while `rst` is high.
- RAM drive (combinational):
  - With a grant g: `ram_addr`/`ram_data_in` = requester g's slices, and `ram_we = req_we[g]`.
  - With no grant: `ram_we = 0`, and `ram_addr`/`ram_data_in` hold the slices of requester `ptr`. These values are don't-care.
- Pointer update:
  - After a grant to g, `ptr <= (g+1) mod NREQ`, wrapping from NREQ-1 to 0.
  - With no grant, `ptr` holds.
- Response path:
  - A granted read sets `rsp_pend <= onehot(g)` on the grant edge. Otherwise `rsp_pend <= 0`.
  - `rsp_valid = rsp_pend`.
  - `rsp_rdata = ram_data_out`, driven combinationally and passed through.
- Writes produce no response. A write is complete at the grant edge.
- Fairness: a continuously valid requester is granted within NREQ cycles of raising valid.

## Timing
- Throughput: one access per cycle, sustained under any request mix. There are no bubbles between back-to-back grants.
- Read latency: the grant is in cycle T. `rsp_valid[g]` and the data are in cycle T+1.
- Read in T+1 after a write in T to the same address returns the newly written data.
- Back-to-back reads from different requesters give responses in consecutive cycles, in grant order.
- Reset values, set at the first edge with `rst` high:
  - `ptr = 0`
  - `rsp_pend = 0`, so `rsp_valid = 0`
  - During reset: `req_ready = 0` and `ram_we = 0`.
- Reset mid-operation:
  - A read granted in the cycle before `rst` rises still returns its response in the `rst` cycle. This follows from `rsp_pend` already being registered.
  - No new grants are issued while `rst` is high.
  - After `rst` falls, arbitration restarts with requester 0 as highest priority.
- Simultaneous events:
  - All requesters valid: grants rotate strictly 0, 1, …, NREQ-1, 0, …
  - Single valid requester: it is granted every cycle regardless of `ptr`.
- Boundary addresses: 0 and DEPTH-1 pass through unmodified. There is no address arithmetic.

## Test plan
- Reset: hold `rst` 2 cycles with all `req_valid` = 1 → `req_ready` = 0, `ram_we` = 0 and `rsp_valid` = 0 throughout. The first grant after release goes to requester 0.
- Single requester streaming (NREQ=2): req 1 writes 0xA5 to addr 0xFF and 0x3C to addr 0x00 in consecutive cycles, then reads 0xFF and 0x00 → 4 grants in 4 cycles. `rsp_valid` = 2'b10 with data 0xA5 at T+1 of the first read, then 0x3C the next cycle.
- Contention (NREQ=2): both requesters continuously valid with reads for 6 cycles → grants alternate 0,1,0,1,0,1. Each `rsp_valid` is one-hot, one cycle behind its grant, and carries the correct requester's data.
- Wrap and fairness (NREQ=3): requesters 1 and 2 valid, `ptr`=2 → grant 2, then 1. Add requester 0 → order 2,0,1,2,0,1, with no requester waiting more than 3 cycles.
- Read-after-write hazard: req 0 writes 0x77 to addr 0x10 in cycle T, req 1 reads 0x10 in T+1 → `rsp_rdata` = 0x77 in T+2 with `rsp_valid` = 2'b10.
- Reset mid-stream: assert `rst` in the cycle after a read grant → that response is still presented in the `rst` cycle. No grants occur during reset, and `ptr` restarts at 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Round-robin arbiter that lets NREQ requesters share one single-port RAM.
// The RAM has a registered read (1-cycle latency). At most one access is
// granted per cycle. Read data comes back to the owning requester one cycle
// after its grant.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  RAM depth (address width AW = $clog2(DEPTH))
//   NREQ   number of requesters (>= 2)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   req_valid     per-requester command valid
//   req_we        per-requester write (1) / read (0)
//   req_addr      packed addresses, requester i in [i*AW +: AW]
//   req_wdata     packed write data, requester i in [i*WIDTH +: WIDTH]
//   req_ready     one-hot grant (zero when idle or in reset)
//   rsp_valid     one-hot read-response valid
//   rsp_rdata     read data, qualified by rsp_valid
//   ram_we        RAM write enable
//   ram_addr      RAM address
//   ram_data_in   RAM write data
//   ram_data_out  RAM registered read data
module ram_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  parameter  int NREQ  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [WIDTH-1:0]      ram_data_in,
  input  logic [WIDTH-1:0]      ram_data_out
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]     NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  rsp_pend_q, rsp_pend_d;

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic             gnt_found;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      scan_w;
  logic             grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
  end

  // Scan ptr, ptr+1, ..., wrapping modulo NREQ. The extra bit in scan_w
  // holds ptr+k before the wrap so non-power-of-two NREQ works.
  // gnt_idx falls back to ptr_q when nothing is valid, which also gives
  // the idle RAM drive values.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    scan_w    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_w = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_w >= NREQ_W) begin
        scan_w = scan_w - NREQ_W;
      end
      if (!gnt_found && req_valid[scan_w[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_w[PW-1:0];
      end
    end
  end

  assign grant = gnt_found && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign ram_we      = grant && req_we[gnt_idx];
  assign ram_addr    = addr_arr[gnt_idx];
  assign ram_data_in = wdata_arr[gnt_idx];

  always_comb begin
    ptr_d      = ptr_q;
    rsp_pend_d = '0;
    if (grant) begin
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
      if (!req_we[gnt_idx]) begin
        rsp_pend_d = req_ready;
      end
    end
  end

  // A response already pending when rst rises is still presented in the
  // rst cycle because rsp_valid comes straight from the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rsp_pend_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  assign rsp_valid = rsp_pend_q;
  assign rsp_rdata = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with NREQ=2 and one with NREQ=3,
// each with its own behavioural RAM. Both see the same stimulus (the NREQ=2
// instance uses requesters 0 and 1); `sel` chooses which one is checked.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  logic ram_init;
  int   sel;
  logic chk_en;

  logic       v    [3];
  logic       we_s [3];
  logic [7:0] a    [3];
  logic [7:0] d    [3];

  int n_checks;
  int n_errors;

  // ---------------- NREQ = 2 instance ----------------
  logic [1:0]  ready2, rspv2;
  logic [7:0]  rdata2, ram_addr2, ram_din2, ram_dout2;
  logic        ram_we2;
  logic [7:0]  mem2 [256];

  ram_arbiter #(.WIDTH(8), .DEPTH(256), .NREQ(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    ({v[1], v[0]}),
    .req_we       ({we_s[1], we_s[0]}),
    .req_addr     ({a[1], a[0]}),
    .req_wdata    ({d[1], d[0]}),
    .req_ready    (ready2),
    .rsp_valid    (rspv2),
    .rsp_rdata    (rdata2),
    .ram_we       (ram_we2),
    .ram_addr     (ram_addr2),
    .ram_data_in  (ram_din2),
    .ram_data_out (ram_dout2)
  );

  // ---------------- NREQ = 3 instance ----------------
  logic [2:0]  ready3, rspv3;
  logic [7:0]  rdata3, ram_addr3, ram_din3, ram_dout3;
  logic        ram_we3;
  logic [7:0]  mem3 [256];

  ram_arbiter #(.WIDTH(8), .DEPTH(256), .NREQ(3)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    ({v[2], v[1], v[0]}),
    .req_we       ({we_s[2], we_s[1], we_s[0]}),
    .req_addr     ({a[2], a[1], a[0]}),
    .req_wdata    ({d[2], d[1], d[0]}),
    .req_ready    (ready3),
    .rsp_valid    (rspv3),
    .rsp_rdata    (rdata3),
    .ram_we       (ram_we3),
    .ram_addr     (ram_addr3),
    .ram_data_in  (ram_din3),
    .ram_data_out (ram_dout3)
  );

  function automatic logic [7:0] pat(int i);
    logic [31:0] t;
    t = i;
    return t[7:0] ^ 8'hC3;
  endfunction

  // Behavioural single-port RAMs with registered read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem2[i] <= pat(i);
    end else if (ram_we2) begin
      mem2[ram_addr2] <= ram_din2;
    end
    ram_dout2 <= mem2[ram_addr2];
  end

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem3[i] <= pat(i);
    end else if (ram_we3) begin
      mem3[ram_addr3] <= ram_din3;
    end
    ram_dout3 <= mem3[ram_addr3];
  end

  // Outputs of the instance under check, widened to 3 requesters.
  logic [2:0] o_ready, o_rsp;
  logic       o_we;
  logic [7:0] o_addr, o_din, o_rdata;

  always_comb begin
    if (sel == 3) begin
      o_ready = ready3;
      o_rsp   = rspv3;
      o_we    = ram_we3;
      o_addr  = ram_addr3;
      o_din   = ram_din3;
      o_rdata = rdata3;
    end else begin
      o_ready = {1'b0, ready2};
      o_rsp   = {1'b0, rspv2};
      o_we    = ram_we2;
      o_addr  = ram_addr2;
      o_din   = ram_din2;
      o_rdata = rdata2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr;
  int         m_pend;      // requester owed a read response, -1 for none
  logic [7:0] m_rdata;
  logic [7:0] m_mem [256];

  function automatic int exp_grant(int n, int ptr);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (ram_init) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= pat(i);
    end
    if (rst) begin
      m_ptr  <= 0;
      m_pend <= -1;
    end else begin
      g = exp_grant(sel, m_ptr);
      m_pend <= -1;
      if (g >= 0) begin
        m_ptr <= (g + 1) % sel;
        if (we_s[g]) begin
          m_mem[a[g]] <= d[g];
        end else begin
          m_pend  <= g;
          m_rdata <= m_mem[a[g]];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int wait_c [3];

  always @(negedge clk) begin
    int         g;
    logic [2:0] ev;
    if (chk_en) begin
      g  = rst ? -1 : exp_grant(sel, m_ptr);
      ev = (g >= 0) ? (3'b001 << g) : 3'b000;
      check("req_ready", {29'd0, o_ready}, {29'd0, ev});
      check("ram_we", {31'd0, o_we}, {31'd0, (g >= 0) ? we_s[g] : 1'b0});
      if (g >= 0) begin
        check("ram_addr", {24'd0, o_addr}, {24'd0, a[g]});
        check("ram_data_in", {24'd0, o_din}, {24'd0, d[g]});
      end
      ev = (m_pend >= 0) ? (3'b001 << m_pend) : 3'b000;
      check("rsp_valid", {29'd0, o_rsp}, {29'd0, ev});
      if (m_pend >= 0) begin
        check("rsp_rdata", {24'd0, o_rdata}, {24'd0, m_rdata});
      end
      for (int i = 0; i < sel; i++) begin
        if (rst || !v[i] || o_ready[i]) begin
          wait_c[i] = 0;
        end else begin
          wait_c[i] = wait_c[i] + 1;
          check("fair_wait_ok", {31'd0, wait_c[i] < sel}, 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input logic vv, input logic ww,
                       input logic [7:0] aa, input logic [7:0] dd);
    v[i]    = vv;
    we_s[i] = ww;
    a[i]    = aa;
    d[i]    = dd;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ord [6];
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) wait_c[i] = 0;
    m_ptr  = 0;
    m_pend = -1;
    sel      = 2;
    chk_en   = 1'b0;
    rst      = 1'b1;
    ram_init = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h40, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h41, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    adv();
    chk_en = 1'b1;

    // Reset held with everyone valid.
    for (int c = 0; c < 2; c++) begin
      settle();
      check("lit_reset_ready", {30'd0, ready2}, 32'd0);
      check("lit_reset_we", {31'd0, ram_we2}, 32'd0);
      check("lit_reset_rsp", {30'd0, rspv2}, 32'd0);
      adv();
    end
    rst      = 1'b0;
    ram_init = 1'b0;
    settle();
    check("lit_first_grant", {30'd0, ready2}, 32'd1);
    adv();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_second_grant", {30'd0, ready2}, 32'd2);
    check("lit_first_rsp_v", {30'd0, rspv2}, 32'd1);
    check("lit_first_rsp_d", {24'd0, rdata2}, 32'h83);
    adv();

    // Single requester streaming, boundary addresses.
    drive(1, 1'b1, 1'b1, 8'hFF, 8'hA5);
    settle();
    check("lit_stream_ready", {30'd0, ready2}, 32'd2);
    check("lit_stream_we", {31'd0, ram_we2}, 32'd1);
    check("lit_stream_addr_ff", {24'd0, ram_addr2}, 32'hFF);
    check("lit_stream_din", {24'd0, ram_din2}, 32'hA5);
    adv();
    drive(1, 1'b1, 1'b1, 8'h00, 8'h3C);
    settle();
    check("lit_stream_addr_00", {24'd0, ram_addr2}, 32'h00);
    adv();
    drive(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    settle();
    check("lit_stream_rd_ready", {30'd0, ready2}, 32'd2);
    check("lit_stream_rd_we", {31'd0, ram_we2}, 32'd0);
    adv();
    drive(1, 1'b1, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_stream_rsp1_v", {30'd0, rspv2}, 32'd2);
    check("lit_stream_rsp1_d", {24'd0, rdata2}, 32'hA5);
    adv();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_stream_rsp2_v", {30'd0, rspv2}, 32'd2);
    check("lit_stream_rsp2_d", {24'd0, rdata2}, 32'h3C);
    adv();

    // Contention: both reading continuously.
    drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h21, 8'h00);
    for (int k = 0; k < 6; k++) begin
      settle();
      check("lit_cont_ready", {30'd0, ready2}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        check("lit_cont_rsp_v", {30'd0, rspv2}, (k % 2 == 0) ? 32'd2 : 32'd1);
        check("lit_cont_rsp_d", {24'd0, rdata2}, (k % 2 == 0) ? 32'hE2 : 32'hE3);
      end
      adv();
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_cont_last_v", {30'd0, rspv2}, 32'd2);
    check("lit_cont_last_d", {24'd0, rdata2}, 32'hE2);
    adv();

    // Read after write to the same address.
    drive(0, 1'b1, 1'b1, 8'h10, 8'h77);
    settle();
    check("lit_raw_wr_ready", {30'd0, ready2}, 32'd1);
    check("lit_raw_wr_we", {31'd0, ram_we2}, 32'd1);
    adv();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    settle();
    check("lit_raw_rd_ready", {30'd0, ready2}, 32'd2);
    adv();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_raw_rsp_v", {30'd0, rspv2}, 32'd2);
    check("lit_raw_rsp_d", {24'd0, rdata2}, 32'h77);
    adv();

    // Reset in the cycle after a read grant.
    drive(0, 1'b1, 1'b0, 8'h30, 8'h00);
    settle();
    check("lit_mid_grant", {30'd0, ready2}, 32'd1);
    adv();
    rst = 1'b1;
    drive(1, 1'b1, 1'b0, 8'h31, 8'h00);
    settle();
    check("lit_mid_rst_ready", {30'd0, ready2}, 32'd0);
    check("lit_mid_rst_we", {31'd0, ram_we2}, 32'd0);
    check("lit_mid_rst_rsp_v", {30'd0, rspv2}, 32'd1);
    check("lit_mid_rst_rsp_d", {24'd0, rdata2}, 32'hF3);
    adv();
    rst = 1'b0;
    settle();
    check("lit_mid_restart", {30'd0, ready2}, 32'd1);
    adv();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    adv();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    adv();

    // ---------------- NREQ = 3 ----------------
    rst      = 1'b1;
    ram_init = 1'b1;
    sel      = 3;
    drive(0, 1'b1, 1'b0, 8'h50, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h51, 8'h00);
    drive(2, 1'b1, 1'b0, 8'h52, 8'h00);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("lit_r3_reset_ready", {29'd0, ready3}, 32'd0);
      adv();
    end
    rst      = 1'b0;
    ram_init = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("lit_r3_setup", {29'd0, ready3}, 32'd2);
    adv();
    drive(2, 1'b1, 1'b0, 8'h52, 8'h00);
    settle();
    check("lit_r3_wrap_g2", {29'd0, ready3}, 32'd4);
    adv();
    settle();
    check("lit_r3_wrap_g1", {29'd0, ready3}, 32'd2);
    check("lit_r3_wrap_rsp_v", {29'd0, rspv3}, 32'd4);
    check("lit_r3_wrap_rsp_d", {24'd0, rdata3}, 32'h91);
    adv();
    drive(0, 1'b1, 1'b0, 8'h50, 8'h00);
    exp_ord = '{2, 0, 1, 2, 0, 1};
    for (int k = 0; k < 6; k++) begin
      settle();
      check("lit_r3_order", {29'd0, ready3}, 32'd1 << exp_ord[k]);
      adv();
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lit_r3_single", {29'd0, ready3}, 32'd1);
      adv();
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    adv();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
